// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage on an 8-bit RAM port; MEM_ALIGN_CHECK_EN traps misaligned H/W accesses.
// Latency: 1 cycle for non-memory ops; a memory op stalls N+2 cycles (load) or N+1 cycles (store), N = bytes.
// Backpressure: stall_out holds upstream for the whole access; inputs are ignored while it is high.
module mem_stage (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdE_in,
    input  logic [4:0]  rdIdx_in,
    input  logic [31:0] rdData_in,
    input  logic [3:0]  memOp_in,
    input  logic [31:0] storeData_in,
    input  logic [7:0]  ramData_in,
    output logic [31:0] ramAddr_out,
    output logic        ramWE_out,
    output logic [7:0]  ramData_out,
    output logic        stall_out,
    output logic        rdE_out,
    output logic [4:0]  rdIdx_out,
    output logic [31:0] rdData_out,
    output logic        misalign_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1, OP_LH  = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                           OP_LHU = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [1:0] op_last(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    state_t      state;
    logic [1:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sdat_q;
    logic [4:0]  idx_q;
    logic        rde_q;
    logic [31:0] buf_q;

    logic        in_mem;
    logic        in_misal;
    logic [1:0]  fill_idx;
    logic [31:0] fill_word;
    logic [31:0] load_val;

    assign in_mem   = op_is_load(memOp_in) || op_is_store(memOp_in);
    // cnt has already advanced past the byte now arriving, so it lands one slot back.
    assign fill_idx = cnt - 2'd1;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    always_comb begin
        case (memOp_in)
            OP_LH, OP_LHU, OP_SH: in_misal = rdData_in[0];
            OP_LW, OP_SW:         in_misal = (rdData_in[1:0] != 2'b00);
            default:              in_misal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state == IDLE) && in_mem && in_misal;
        end
    end

    assign misalign_out = misalign_q;
`else
    assign in_misal     = 1'b0;
    assign misalign_out = 1'b0;
`endif

    always_comb begin
        fill_word = buf_q;
        fill_word[{fill_idx, 3'b000} +: 8] = ramData_in;
    end

    always_comb begin
        case (op_q)
            OP_LB:   load_val = {{24{fill_word[7]}}, fill_word[7:0]};
            OP_LH:   load_val = {{16{fill_word[15]}}, fill_word[15:0]};
            OP_LBU:  load_val = {24'd0, fill_word[7:0]};
            OP_LHU:  load_val = {16'd0, fill_word[15:0]};
            default: load_val = fill_word;
        endcase
    end

    always_comb begin
        ramAddr_out = 32'd0;
        ramWE_out   = 1'b0;
        ramData_out = 8'd0;
        if (state == ACCESS) begin
            ramAddr_out = addr_q + {30'd0, cnt};
            if (op_is_store(op_q)) begin
                ramWE_out   = 1'b1;
                ramData_out = sdat_q[{cnt, 3'b000} +: 8];
            end
        end
    end

    // Gated by reset so the IDLE decode of memOp_in cannot raise stall while held in reset.
    always_comb begin
        case (state)
            IDLE:        stall_out = rst_in && in_mem;
            ACCESS, WAIT: stall_out = 1'b1;
            default:     stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            op_q       <= 4'd0;
            addr_q     <= 32'd0;
            sdat_q     <= 32'd0;
            idx_q      <= 5'd0;
            rde_q      <= 1'b0;
            buf_q      <= 32'd0;
            rdE_out    <= 1'b0;
            rdIdx_out  <= 5'd0;
            rdData_out <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_mem) begin
                        op_q    <= memOp_in;
                        addr_q  <= rdData_in;
                        sdat_q  <= storeData_in;
                        idx_q   <= rdIdx_in;
                        rde_q   <= rdE_in;
                        cnt     <= 2'd0;
                        rdE_out <= 1'b0;
                        state   <= in_misal ? DONE : ACCESS;
                    end else begin
                        rdE_out    <= rdE_in;
                        rdIdx_out  <= rdIdx_in;
                        rdData_out <= rdData_in;
                    end
                end
                ACCESS: begin
                    if (op_is_load(op_q) && (cnt != 2'd0)) begin
                        buf_q <= fill_word;
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == op_last(op_q)) begin
                        state <= op_is_load(op_q) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    buf_q      <= fill_word;
                    rdData_out <= load_val;
                    rdE_out    <= rde_q;
                    rdIdx_out  <= idx_q;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (rst_in low = reset), with no other clock or reset inputs.
REQ-002 clk_in  input  1  stage clock, rising edge.
REQ-003 rst_in  input  1  asynchronous active-low reset.
REQ-004 rdE_in  input  1  EX result writes rd.
REQ-005 rdIdx_in  input  5  destination register index.
REQ-006 rdData_in  input  32  EX result; byte address for memory ops.
REQ-007 memOp_in  input  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-008 storeData_in  input  32  rs2 value for stores.
REQ-009 ramData_in  input  8  RAM read byte, valid one cycle after address issue.
REQ-010 ramAddr_out  output  32  RAM byte address.
REQ-011 ramWE_out  output  1  RAM write strobe.
REQ-012 ramData_out  output  8  RAM write byte.
REQ-013 stall_out  output  1  upstream SHALL hold its inputs while high.
REQ-014 rdE_out, rdIdx_out, rdData_out  output  1/5/32  registered writeback fields.
REQ-015 misalign_out  output  1  misaligned-access flag, one cycle.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCESS, WAIT, DONE, with a 2-bit byte counter cnt and a byte count N of 1 (B), 2 (H) or 4 (W).
REQ-017 In IDLE with memOp NONE: stall_out=0; at each edge rd*_out <= rd*_in; 1-cycle latency.
REQ-018 In IDLE with a load/store: stall_out=1 combinationally; at the edge, capture the address, store data, op, rdIdx; cnt<=0; rdE_out<=0; go to ACCESS.
REQ-019 In ACCESS: ramAddr_out = addr+cnt (mod 2^32, little-endian); for stores, ramWE_out=1 and ramData_out = storeData byte cnt; for loads, ramWE_out=0.
REQ-020 During a load, the byte on ramData_in in each cycle after an ACCESS cycle SHALL be stored into buffer byte cnt-1.
REQ-021 ACCESS with cnt=N-1 SHALL go to WAIT for loads and to DONE for stores; otherwise cnt increments.
REQ-022 WAIT SHALL capture the final byte and, at the edge into DONE, load rdData_out with the sign-extended (LB/LH) or zero-extended (LBU/LHU/LW) result, rdE_out=rdE_in captured, and rdIdx_out=captured index.
REQ-023 stall_out SHALL be 1 in ACCESS and WAIT and 0 in DONE; DONE SHALL ignore all inputs and return to IDLE after 1 cycle.
REQ-024 Stores SHALL leave rdE_out=0; rd*_out SHALL be held in DONE.
REQ-025 Outside ACCESS: ramWE_out=0, ramAddr_out=0, ramData_out=0.
REQ-026 The stall cycles per memory op SHALL be N+2 for a load and N+1 for a store; the load result is visible in DONE.
REQ-027 Input changes while stall_out=1 SHALL have no effect.

Reset
REQ-028 rst_in low SHALL immediately force IDLE, cnt=0, buffer=0, and all outputs 0 (rdIdx_out=0), including mid-ACCESS, where ramWE_out drops asynchronously.
REQ-029 After rst_in releases, the first edge SHALL behave as IDLE.

Configuration
REQ-030 With MEM_ALIGN_CHECK_EN defined, LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL go IDLE->DONE with no RAM access, rdE_out=0, and misalign_out=1 in DONE only.
REQ-031 With MEM_ALIGN_CHECK_EN undefined, misaligned ops SHALL run byte-serially as in REQ-019, and misalign_out SHALL be tied to 0.

Verification
REQ-032 memOp=NONE, rdE=1, rdIdx=5, rdData=0x1234 -> next cycle rd*_out = 1/5/0x1234, stall_out never high.
REQ-033 SW addr 0x100, data 0xAABBCCDD -> writes DD,CC,BB,AA to 0x100-0x103 on consecutive cycles, stall_out high 5 cycles, rdE_out=0.
REQ-034 LB addr 0x200, RAM byte 0x80 -> rdData_out=0xFFFFFF80 in DONE; LBU -> 0x00000080; stall_out high 3 cycles.
REQ-035 LW addr 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1 (macro undefined); with the macro defined -> no RAM access and misalign_out pulses once.
REQ-036 rst_in low during the 2nd ACCESS cycle of SH -> ramWE_out=0 at once, IDLE after release, no further writes.
